// File: rtl/custom_instr_pkg.sv
// Shared definitions for the custom execution-unit issue path: unit opcodes,
// the opcode-to-unit table and the issue controller state type.
package custom_instr_pkg;

    localparam int MAX_UNITS = 4;

    // Units live in the RISC-V custom-0..3 major opcode slots.
    localparam logic [6:0] OPCODE_CNTB    = 7'h0B;
    localparam logic [6:0] OPCODE_CUSTOM1 = 7'h2B;
    localparam logic [6:0] OPCODE_CUSTOM2 = 7'h5B;
    localparam logic [6:0] OPCODE_CUSTOM3 = 7'h7B;

    localparam logic [6:0] UNIT_OPCODE [MAX_UNITS] = '{
        OPCODE_CNTB, OPCODE_CUSTOM1, OPCODE_CUSTOM2, OPCODE_CUSTOM3
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RESULT = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/custom_ctrl_watchdog.sv
// Busy-cycle watchdog: 8-bit up-counter with clear/enable; flags the cycle in
// which the TIMEOUT_CYCLES-th consecutive enabled cycle is reached.
module custom_ctrl_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic timeout_o
);

    logic [7:0] count_q, count_d;

    // The clearing cycle itself is counted, so count_q equals the number of
    // enabled cycles already elapsed since the clear.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {7'd0, enable_i};
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = enable_i & ~clear_i & (count_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/custom_issue_ctrl.sv
// Issue controller between the X-IF issue/result channels and a bank of custom
// execution units: decode, dispatch, watchdog supervision and result return.
module custom_issue_ctrl
    import custom_instr_pkg::*;
#(
    parameter int NUM_UNITS      = 2,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [31:0]             issue_instr_i,
    input  logic [31:0]             issue_rs0_i,
    input  logic [31:0]             issue_rs1_i,
    input  logic [ID_WIDTH-1:0]     issue_id_i,
    output logic                    issue_accept_o,
    output logic                    issue_writeback_o,
    input  logic                    kill_i,
    output logic [NUM_UNITS-1:0]    unit_start_o,
    output logic [NUM_UNITS-1:0]    unit_abort_o,
    output logic [31:0]             unit_rs0_o,
    output logic [31:0]             unit_rs1_o,
    input  logic [NUM_UNITS-1:0]    unit_done_i,
    input  logic [NUM_UNITS*32-1:0] unit_result_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [ID_WIDTH-1:0]     result_id_o,
    output logic [4:0]              result_rd_o,
    output logic [31:0]             result_data_o,
    output logic                    result_err_o
);

    localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    ctrl_state_e         state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d, dec_sel;
    logic                first_q, first_d;
    logic [31:0]         rs0_q, rs0_d, rs1_q, rs1_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [4:0]          rd_q, rd_d;
    logic [31:0]         data_q, data_d;
    logic                err_q, err_d;

    logic                dec_match;
    logic                issue_hs;
    logic                done_sel;
    logic                wd_timeout;
    logic [NUM_UNITS-1:0] sel_oh;
    logic [31:0]         sel_result;
    logic                unused_instr;

    // Lowest-indexed unit wins if two table entries share an opcode.
    always_comb begin
        dec_match = 1'b0;
        dec_sel   = '0;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            if (issue_instr_i[6:0] == UNIT_OPCODE[k]) begin
                dec_match = 1'b1;
                dec_sel   = SEL_W'(k);
            end
        end
    end

    assign issue_accept_o    = dec_match;
    assign issue_writeback_o = dec_match & (|issue_instr_i[11:7]);
    assign unused_instr      = ^issue_instr_i[31:12];

    assign issue_hs   = issue_valid_i & issue_ready_o;
    assign sel_oh     = NUM_UNITS'(1) << sel_q;
    assign sel_result = unit_result_i[32'(sel_q) * 32 +: 32];
    // Done in the start cycle belongs to nothing we dispatched.
    assign done_sel   = (state_q == ST_BUSY) & ~first_q & unit_done_i[sel_q];

    custom_ctrl_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   ((state_q == ST_BUSY) & first_q),
        .enable_i  (state_q == ST_BUSY),
        .timeout_o (wd_timeout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            first_q <= 1'b0;
            rs0_q   <= 32'd0;
            rs1_q   <= 32'd0;
            id_q    <= '0;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            first_q <= first_d;
            rs0_q   <= rs0_d;
            rs1_q   <= rs1_d;
            id_q    <= id_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // kill_i outranks done, timeout and the result handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_hs & dec_match) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (kill_i)                       state_d = ST_IDLE;
                else if (done_sel | wd_timeout)   state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (kill_i | result_ready_i)      state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d   = sel_q;
        first_d = 1'b0;
        rs0_d   = rs0_q;
        rs1_d   = rs1_q;
        id_d    = id_q;
        rd_d    = rd_q;
        data_d  = data_q;
        err_d   = err_q;
        if ((state_q == ST_IDLE) && issue_hs && dec_match) begin
            sel_d   = dec_sel;
            first_d = 1'b1;
            rs0_d   = issue_rs0_i;
            rs1_d   = issue_rs1_i;
            id_d    = issue_id_i;
            rd_d    = issue_instr_i[11:7];
        end
        if ((state_q == ST_BUSY) && !kill_i) begin
            if (done_sel) begin
                data_d = sel_result;
                err_d  = 1'b0;
            end else if (wd_timeout) begin
                data_d = 32'd0;
                err_d  = 1'b1;
            end
        end
    end

    always_comb begin
        issue_ready_o = (state_q == ST_IDLE) & ~kill_i;
        unit_start_o  = '0;
        unit_abort_o  = '0;
        if (state_q == ST_BUSY) begin
            if (first_q) unit_start_o = sel_oh;
            if (kill_i | (wd_timeout & ~done_sel)) unit_abort_o = sel_oh;
        end
    end

    assign result_valid_o = (state_q == ST_RESULT);
    assign result_id_o    = id_q;
    assign result_rd_o    = rd_q;
    assign result_data_o  = data_q;
    assign result_err_o   = err_q;
    assign unit_rs0_o     = rs0_q;
    assign unit_rs1_o     = rs1_q;

endmodule
